// File: rtl/layer5_pkg.sv
// layer5_pkg: shared constants, derived widths and state encoding for the layer-5 sequencer
package layer5_pkg;
  localparam int N_IN  = 48;
  localparam int N_OUT = 10;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int WA_W  = 6;
  localparam int DRAIN = 3;
  localparam int CW    = $clog2(N_IN);
  localparam int LW    = $clog2(N_OUT);
  localparam int DCW   = $clog2(DRAIN + 1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAIN,
    S_ARGMAX,
    S_DONE
  } state_e;
endpackage

// File: rtl/argmax_seq.sv
// argmax_seq: sequential signed argmax over lanes presented one per cycle; lower index wins ties
module argmax_seq
  import layer5_pkg::*;
#(
  parameter int IW = LW,
  parameter int VW = AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          vld_i,
  input  logic          last_i,
  input  logic [IW-1:0] idx_i,
  input  logic [VW-1:0] val_i,
  output logic [IW-1:0] best_idx_o,
  output logic [VW-1:0] best_val_o,
  output logic          done_o
);
  logic [IW-1:0] run_idx_q, run_idx_d, res_idx_q, res_idx_d;
  logic [VW-1:0] run_val_q, run_val_d, res_val_q, res_val_d;
  logic          done_q, done_d, take, fin;
  // first lane seeds the running best; later lanes replace it only when strictly greater
  always_comb begin
    take      = vld_i && (start_i || $signed(val_i) > $signed(run_val_q));
    fin       = vld_i && last_i;
    run_idx_d = take ? idx_i : run_idx_q;
    run_val_d = take ? val_i : run_val_q;
    res_idx_d = fin ? run_idx_d : res_idx_q;
    res_val_d = fin ? run_val_d : res_val_q;
    done_d    = fin;
  end
  // running best plus a result copy that stays stable until the next scan completes
  always_ff @(posedge clk) begin
    if (rst) begin
      run_idx_q <= '0;
      run_val_q <= '0;
      res_idx_q <= '0;
      res_val_q <= '0;
      done_q    <= 1'b0;
    end else begin
      run_idx_q <= run_idx_d;
      run_val_q <= run_val_d;
      res_idx_q <= res_idx_d;
      res_val_q <= res_val_d;
      done_q    <= done_d;
    end
  end
  assign best_idx_o = res_idx_q;
  assign best_val_o = res_val_q;
  assign done_o     = done_q;
endmodule

// File: rtl/layer5_seq_ctrl.sv
// layer5_seq_ctrl: feature intake, MAC-array sequencing and argmax for the 10-class output layer
module layer5_seq_ctrl
  import layer5_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                feat_valid_i,
  input  logic [DW-1:0]       feat_data_i,
  output logic                feat_ready_o,
  output logic [WA_W-1:0]     w_addr_o,
  output logic                mac_clear_o,
  output logic                mac_en_o,
  output logic [DW-1:0]       mac_din_o,
  input  logic [AW*N_OUT-1:0] acc_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [LW-1:0]       class_o,
  output logic [AW-1:0]       score_o
);
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WA_W-1:0] w_addr_q, w_addr_d;
  logic [DW-1:0]   feat_q, feat_d, din_q, din_d;
  logic            hs_q, hs_d, en_q, en_d, hs, last_feat;
  logic [DCW-1:0]  drain_q, drain_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic [AW-1:0]   lane_val;
  // next state, handshake, counters and the address/data alignment pipeline
  always_comb begin
    state_d      = state_q;
    feat_ready_o = state_q == S_LOAD;
    mac_clear_o  = state_q == S_CLEAR;
    busy_o       = state_q != S_IDLE;
    hs           = feat_ready_o && feat_valid_i;
    last_feat    = cnt_q == CW'(N_IN - 1);
    cnt_d        = state_q == S_CLEAR ? '0 : hs && !last_feat ? cnt_q + 1'b1 : cnt_q;
    w_addr_d     = hs ? WA_W'(cnt_q) : w_addr_q;
    feat_d       = hs ? feat_data_i : feat_q;
    hs_d         = hs;
    en_d         = hs_q;
    din_d        = feat_q;
    drain_d      = state_q == S_DRAIN ? drain_q + 1'b1 : '0;
    lane_d       = state_q == S_ARGMAX ? lane_q + 1'b1 : '0;
    case (state_q)
      S_IDLE:   state_d = start_i ? S_CLEAR : S_IDLE;
      S_CLEAR:  state_d = S_LOAD;
      S_LOAD:   state_d = hs && last_feat ? S_DRAIN : S_LOAD;
      S_DRAIN:  state_d = drain_q == DCW'(DRAIN) ? S_ARGMAX : S_DRAIN;
      S_ARGMAX: state_d = lane_q == LW'(N_OUT - 1) ? S_DONE : S_ARGMAX;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any inference in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      w_addr_q <= '0;
      feat_q   <= '0;
      din_q    <= '0;
      hs_q     <= 1'b0;
      en_q     <= 1'b0;
      drain_q  <= '0;
      lane_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_addr_q <= w_addr_d;
      feat_q   <= feat_d;
      din_q    <= din_d;
      hs_q     <= hs_d;
      en_q     <= en_d;
      drain_q  <= drain_d;
      lane_q   <= lane_d;
    end
  end
  assign lane_val  = acc_i[32'(lane_q)*AW +: AW];
  assign w_addr_o  = w_addr_q;
  assign mac_en_o  = en_q;
  assign mac_din_o = din_q;
  argmax_seq #(.IW(LW), .VW(AW)) u_argmax (
    .clk       (clk_i),
    .rst       (rst_i),
    .start_i   (state_q == S_ARGMAX && lane_q == '0),
    .vld_i     (state_q == S_ARGMAX),
    .last_i    (lane_q == LW'(N_OUT - 1)),
    .idx_i     (lane_q),
    .val_i     (lane_val),
    .best_idx_o(class_o),
    .best_val_o(score_o),
    .done_o    (done_o)
  );
endmodule
